// File: rtl/accumulator_bus_controller.sv
// Bus arbiter and operand-memory sequencer for a cluster of accumulator
// processors. Operands live in a circular memory: FETCH pops from rd_ptr,
// SEND pushes a partial sum at wr_ptr. Each processor does two FETCHes and
// one SEND per step, so operands are reserved in pairs to avoid deadlock.
module accumulator_bus_controller #(
    parameter int NUM_PROC = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   init_count,
    input  logic [NUM_PROC-1:0] req,
    output logic [NUM_PROC-1:0] grant,
    input  logic [1:0]          op,
    output logic                signal,
    output logic [DATA_W-1:0]   read,
    input  logic [DATA_W-1:0]   write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [ADDR_W:0]     avail,
    output logic                done,
    output logic                proto_err
);

    localparam int IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int AW1   = ADDR_W + 1;

    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_WAIT_OP, S_RD, S_FETCH_ACK, S_WR, S_DONE
    } state_t;

    state_t              r_state;
    logic [NUM_PROC-1:0] r_grant;
    logic                r_signal;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_re;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [ADDR_W:0]     r_avail;
    logic [ADDR_W:0]     r_reserved;
    logic                r_done;
    logic                r_proto_err;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [1:0]          r_phase [NUM_PROC];

    logic [ADDR_W:0]     w_free;
    logic [NUM_PROC-1:0] w_elig;
    logic                w_all_idle;
    logic                w_pick_vld;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_eff_fetch;
    logic                w_op_valid;
    logic                w_op_bad;

    assign grant     = r_grant;
    assign signal    = r_signal;
    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign avail     = r_avail;
    assign done      = r_done;
    assign proto_err = r_proto_err;

    // Fetched data is only presented while the fetch strobe is up.
    assign read = (r_state == S_FETCH_ACK) ? mem_rdata : '0;

    // Operands not yet promised to a processor that is mid-step.
    assign w_free = r_avail - r_reserved;

    // The granted processor's phase decides what the transfer really is.
    assign w_eff_fetch = (r_phase[r_rr_ptr] != 2'd2);
    assign w_op_valid  = (op == OP_FETCH) || (op == OP_SEND);
    assign w_op_bad    = ((op == OP_FETCH) && !w_eff_fetch) ||
                         ((op == OP_SEND) && w_eff_fetch);

    // Eligibility: mid-step processors always, fresh ones only if a pair is free.
    always_comb begin
        w_elig     = '0;
        w_all_idle = 1'b1;
        for (int i = 0; i < NUM_PROC; i++) begin
            w_elig[i] = req[i] && ((r_phase[i] != 2'd0) || (w_free >= AW1'(2)));
            if (r_phase[i] != 2'd0) begin
                w_all_idle = 1'b0;
            end
        end
    end

    // Round-robin pick: first eligible requester after the last grantee.
    always_comb begin
        int j;
        j          = 0;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = 1; k <= NUM_PROC; k++) begin
            j = (int'(r_rr_ptr) + k) % NUM_PROC;
            if (!w_pick_vld && w_elig[IDX_W'(j)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = IDX_W'(j);
            end
        end
    end

    // Main sequencer: arbitration, transfer handshakes and operand bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_signal    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_avail     <= '0;
            r_reserved  <= '0;
            r_done      <= 1'b0;
            r_proto_err <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_rr_ptr    <= '0;
            for (int i = 0; i < NUM_PROC; i++) begin
                r_phase[i] <= 2'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rd_ptr   <= '0;
                        r_wr_ptr   <= init_count;
                        r_avail    <= {1'b0, init_count};
                        r_reserved <= '0;
                        r_state    <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_all_idle && (r_avail <= AW1'(1))) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_pick_vld) begin
                        r_grant  <= NUM_PROC'(1) << w_pick_idx;
                        r_rr_ptr <= w_pick_idx;
                        if (r_phase[w_pick_idx] == 2'd0) begin
                            r_reserved <= r_reserved + AW1'(2);
                        end
                        r_state <= S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    if (w_op_valid) begin
                        if (w_op_bad) begin
                            r_proto_err <= 1'b1;
                        end
                        if (w_eff_fetch) begin
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= r_rd_ptr;
                            r_state    <= S_RD;
                        end else begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_wr_ptr;
                            r_mem_wdata <= write;
                            r_signal    <= 1'b1;
                            r_state     <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    r_mem_re <= 1'b0;
                    r_signal <= 1'b1;
                    r_state  <= S_FETCH_ACK;
                end
                S_FETCH_ACK: begin
                    r_signal            <= 1'b0;
                    r_grant             <= '0;
                    r_rd_ptr            <= r_rd_ptr + ADDR_W'(1);
                    r_avail             <= r_avail - AW1'(1);
                    r_reserved          <= r_reserved - AW1'(1);
                    r_phase[r_rr_ptr]   <= r_phase[r_rr_ptr] + 2'd1;
                    r_state             <= S_ARB;
                end
                S_WR: begin
                    r_mem_we          <= 1'b0;
                    r_signal          <= 1'b0;
                    r_grant           <= '0;
                    r_wr_ptr          <= r_wr_ptr + ADDR_W'(1);
                    r_avail           <= r_avail + AW1'(1);
                    r_phase[r_rr_ptr] <= 2'd0;
                    r_state           <= S_ARB;
                end
                S_DONE: begin
                    r_grant <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_bus_controller.sv
// Bench for accumulator_bus_controller: two instances (8-bit and 3-bit
// address) with their own sync RAMs, a shared processor model driving the
// bus, and a FIFO-queue reference of the operand memory.
module tb_accumulator_bus_controller;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;

    logic        clk;
    logic        reset;
    logic        start_a, start_b;
    logic [7:0]  init_count;
    logic [3:0]  req;
    logic [1:0]  op;
    logic [31:0] write;

    logic [3:0]  grant_a, grant_b;
    logic        signal_a, signal_b;
    logic [31:0] read_a, read_b;
    logic [7:0]  mem_addr_a;
    logic [2:0]  mem_addr_b;
    logic        mem_re_a, mem_re_b, mem_we_a, mem_we_b;
    logic [31:0] mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
    logic [8:0]  avail_a;
    logic [3:0]  avail_b;
    logic        done_a, done_b, perr_a, perr_b;

    logic        sel;
    logic [3:0]  grant_m;
    logic        signal_m, mem_re_m, mem_we_m, done_m, perr_m;
    logic [31:0] read_m, mem_wdata_m;
    logic [7:0]  mem_addr_m;
    logic [8:0]  avail_m;

    logic [31:0] ram_a [256];
    logic [31:0] ram_b [8];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    int          vectors, errors;
    logic [31:0] vals [32];
    logic [31:0] q [$];
    int          gseq [$];
    int          pst [4];
    logic [31:0] pa [4];
    logic [31:0] pb [4];

    accumulator_bus_controller #(.NUM_PROC(4), .DATA_W(32), .ADDR_W(8)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .init_count(init_count),
        .req(req), .grant(grant_a), .op(op), .signal(signal_a), .read(read_a),
        .write(write), .mem_addr(mem_addr_a), .mem_re(mem_re_a), .mem_we(mem_we_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .avail(avail_a),
        .done(done_a), .proto_err(perr_a)
    );

    accumulator_bus_controller #(.NUM_PROC(4), .DATA_W(32), .ADDR_W(3)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .init_count(init_count[2:0]),
        .req(req), .grant(grant_b), .op(op), .signal(signal_b), .read(read_b),
        .write(write), .mem_addr(mem_addr_b), .mem_re(mem_re_b), .mem_we(mem_we_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .avail(avail_b),
        .done(done_b), .proto_err(perr_b)
    );

    assign grant_m     = sel ? grant_b : grant_a;
    assign signal_m    = sel ? signal_b : signal_a;
    assign read_m      = sel ? read_b : read_a;
    assign mem_addr_m  = sel ? {5'b0, mem_addr_b} : mem_addr_a;
    assign mem_re_m    = sel ? mem_re_b : mem_re_a;
    assign mem_we_m    = sel ? mem_we_b : mem_we_a;
    assign mem_wdata_m = sel ? mem_wdata_b : mem_wdata_a;
    assign avail_m     = sel ? {5'b0, avail_b} : avail_a;
    assign done_m      = sel ? done_b : done_a;
    assign perr_m      = sel ? perr_b : perr_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs with a bench-side load port.
    always @(posedge clk) begin
        if (ld_en && !sel) ram_a[ld_addr] <= ld_data;
        if (ld_en && sel)  ram_b[ld_addr[2:0]] <= ld_data;
        if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
        if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
        if (mem_re_a) mem_rdata_a <= ram_a[mem_addr_a];
        if (mem_re_b) mem_rdata_b <= ram_b[mem_addr_b];
    end

    function automatic logic [31:0] ram_rd(input logic [7:0] a);
        return sel ? ram_b[a[2:0]] : ram_a[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; req = '0;
        op = OP_NOP; write = '0; ld_en = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'({grant_m, signal_m, mem_re_m, mem_we_m, mem_addr_m,
                                  avail_m, done_m, perr_m, mem_wdata_m}), 64'(0));
        reset = 1'b0;
    endtask

    task automatic load(input int n);
        q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = vals[i];
            q.push_back(vals[i]);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Processor cluster model plus queue reference; runs one reduction.
    task automatic run_red(input int n, input logic [3:0] act, input bit rnd,
                           input bit bad, input bit abort_rd, input int max_cyc);
        int k, iss_k, nb;
        bit bad_pend, issued, prev_sig, prev_gnt, gv, saw_re;
        logic [1:0]  g;
        logic [31:0] expv;
        for (int i = 0; i < 4; i++) begin
            pst[i] = 0; pa[i] = '0; pb[i] = '0;
        end
        gseq.delete();
        @(negedge clk);
        init_count = 8'(n);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        k = 0; iss_k = 0; issued = 0; prev_sig = 0; prev_gnt = 0; saw_re = 0;
        bad_pend = bad;
        while (done_m !== 1'b1 && k < max_cyc) begin
            if (abort_rd && mem_re_m === 1'b1) begin
                saw_re = 1;
                break;
            end
            gv = 0; g = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (grant_m[i]) begin gv = 1; g = 2'(i); end
            end
            chk("grant_onehot", 64'($onehot0(grant_m)), 64'(1));
            chk("avail_bound", 64'(int'(avail_m) <= n), 64'(1));
            if (!signal_m) chk("read_idle_zero", 64'(read_m), 64'(0));
            if (gv && !prev_gnt) begin
                gseq.push_back(int'(g));
                if (pst[g] == 0) begin
                    nb = 0;
                    for (int i = 0; i < 4; i++) if (pst[i] == 1) nb++;
                    chk("reserve_rule", 64'((q.size() - nb) >= 2), 64'(1));
                end
            end
            if (signal_m) begin
                chk("sig_one_cycle", 64'(prev_sig), 64'(0));
                chk("sig_with_grant", 64'(gv), 64'(1));
                chk("avail_at_xfer", 64'(avail_m), 64'(q.size()));
                if (pst[g] < 2) begin
                    chk("fetch_latency", 64'(k - iss_k), 64'(2));
                    if (q.size() == 0) begin
                        chk("fetch_nonempty", 64'(0), 64'(1));
                    end else begin
                        expv = q.pop_front();
                        chk("fetch_data", 64'(read_m), 64'(expv));
                    end
                    if (pst[g] == 0) pa[g] = read_m; else pb[g] = read_m;
                    pst[g]++;
                end else begin
                    chk("send_latency", 64'(k - iss_k), 64'(1));
                    q.push_back(pa[g] + pb[g]);
                    pst[g] = 0;
                end
                issued = 0;
            end
            op = OP_NOP;
            write = $urandom;
            if (gv && !issued && !signal_m && (!rnd || $urandom_range(0, 2) == 0)) begin
                op = (pst[g] < 2) ? OP_FETCH : OP_SEND;
                if (bad_pend && pst[g] == 0) begin
                    op = OP_SEND;
                    bad_pend = 0;
                end
                if (pst[g] == 2) write = pa[g] + pb[g];
                issued = 1;
                iss_k = k;
            end
            for (int i = 0; i < 4; i++) begin
                req[i] = act[i] && (!rnd || $urandom_range(0, 3) != 0);
            end
            prev_sig = signal_m;
            prev_gnt = gv;
            @(negedge clk);
            k++;
        end
        if (!abort_rd) begin
            op = OP_NOP;
            req = '0;
            chk("reduction_done", 64'(done_m), 64'(1));
        end else begin
            chk("rd_reached", 64'(saw_re), 64'(1));
        end
    endtask

    task automatic final_chk(input int n, input bit perr_exp);
        logic [31:0] total;
        logic [7:0]  fa;
        total = '0;
        for (int i = 0; i < n; i++) total = total + vals[i];
        chk("done", 64'(done_m), 64'(1));
        chk("avail_end", 64'(avail_m), 64'((n == 0) ? 0 : 1));
        if (n > 0) begin
            fa = 8'((2 * (n - 1)) % (sel ? 8 : 256));
            chk("final_sum", 64'(ram_rd(fa)), 64'(total));
        end
        chk("proto_err", 64'(perr_m), 64'(perr_exp));
        req = 4'hF;
        repeat (3) @(negedge clk);
        chk("done_no_grant", 64'(grant_m), 64'(0));
        chk("done_sticky", 64'(done_m), 64'(1));
        req = '0;
    endtask

    initial begin
        int exp_g [4];
        int n;
        vectors = 0; errors = 0; sel = 1'b0;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; init_count = '0;
        req = '0; op = OP_NOP; write = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(negedge clk);

        // Single processor, 5 + 7.
        do_reset();
        vals[0] = 32'd5; vals[1] = 32'd7;
        load(2);
        run_red(2, 4'b0001, 0, 0, 0, 2000);
        chk("single_ram2", 64'(ram_rd(8'd2)), 64'(12));
        final_chk(2, 0);

        // Four processors, values 1..8, round-robin order.
        do_reset();
        for (int i = 0; i < 8; i++) vals[i] = 32'(i + 1);
        load(8);
        run_red(8, 4'hF, 0, 0, 0, 4000);
        exp_g = '{1, 2, 3, 0};
        chk("rr_grants_seen", 64'(gseq.size() >= 4), 64'(1));
        if (gseq.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", 64'(gseq[i]), 64'(exp_g[i]));
        end
        chk("sum36", 64'(ram_rd(8'd14)), 64'(36));
        final_chk(8, 0);

        // Reservation: three operands, four processors.
        do_reset();
        for (int i = 0; i < 3; i++) vals[i] = $urandom;
        load(3);
        run_red(3, 4'hF, 0, 0, 0, 2000);
        chk("resv_grants_seen", 64'(gseq.size() >= 3), 64'(1));
        if (gseq.size() >= 3) begin
            for (int i = 0; i < 3; i++) chk("resv_same_proc", 64'(gseq[i]), 64'(1));
        end
        final_chk(3, 0);

        // Pointer wrap on the 3-bit address instance.
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) vals[i] = $urandom;
        load(7);
        run_red(7, 4'hF, 1, 0, 0, 6000);
        final_chk(7, 0);
        sel = 1'b0;

        // Protocol error: SEND issued in phase 0 is handled as FETCH.
        do_reset();
        for (int i = 0; i < 2; i++) vals[i] = $urandom;
        load(2);
        run_red(2, 4'b0001, 0, 1, 0, 2000);
        final_chk(2, 1);

        // Reset while a fetch is in RD, then a clean restart.
        do_reset();
        vals[0] = 32'd5; vals[1] = 32'd7;
        load(2);
        run_red(2, 4'b0001, 0, 0, 1, 200);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rd_outs", 64'({grant_m, signal_m, mem_re_m, done_m}), 64'(0));
        chk("rst_rd_avail", 64'(avail_m), 64'(0));
        reset = 1'b0;
        q.delete(); q.push_back(32'd5); q.push_back(32'd7);
        run_red(2, 4'b0001, 0, 0, 0, 2000);
        chk("restart_ram2", 64'(ram_rd(8'd2)), 64'(12));
        final_chk(2, 0);

        // Boundary counts: zero and one operand finish at once.
        do_reset();
        load(0);
        run_red(0, 4'hF, 1, 0, 0, 100);
        final_chk(0, 0);
        do_reset();
        vals[0] = $urandom;
        load(1);
        run_red(1, 4'hF, 1, 0, 0, 100);
        final_chk(1, 0);

        // Randomized reductions with random processor subsets.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            n = $urandom_range(2, 30);
            for (int i = 0; i < n; i++) vals[i] = $urandom;
            load(n);
            run_red(n, 4'($urandom_range(1, 15)), 1, 0, 0, 20000);
            final_chk(n, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/accumulator_bus_controller.md
Name: accumulator_bus_controller

Overview:
- Central bus arbiter and operand-memory sequencer for a cluster of accumulator processors sharing one req/grant/op/signal/read/write bus.
- Grants the bus round-robin and serves FETCH by popping an operand from a circular operand memory. Serves SEND by pushing the result back.
- Reserves operands so no processor can deadlock holding a single operand.
- Raises done when exactly one operand (the final sum) remains.

Parameters:
NUM_PROC, 4, number of processors (req/grant width)
DATA_W, 32, operand width
ADDR_W, 8, operand memory address width; max operands 2^ADDR_W-1

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; begins reduction of init_count preloaded operands (addresses 0..init_count-1)
init_count  input  ADDR_W  operand count sampled on start
req  input  NUM_PROC  per-processor bus request
grant  output  NUM_PROC  one-hot bus grant, registered
op  input  2  shared bus op: 00 NOP, 01 FETCH, 10 SEND
signal  output  1  transfer-complete strobe, one cycle
read  output  DATA_W  fetched operand; equals mem_rdata while signal is high for a FETCH, else 0
write  input  DATA_W  result from granted processor
mem_addr  output  ADDR_W  sync RAM address, registered
mem_re  output  1  RAM read enable; rdata valid the cycle after
mem_we  output  1  RAM write enable
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data
avail  output  ADDR_W+1  operands currently in memory
done  output  1  sticky; reduction complete
proto_err  output  1  sticky; op sequence violation

Behaviour:
- Reset values: grant=0, signal=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, avail=0, done=0, proto_err=0. Internally rd_ptr=0, wr_ptr=0, reserved=0, all phase=0, rr_ptr=0, state IDLE. Reset mid-transaction aborts immediately; RAM contents are untouched.
- States: IDLE, ARB, WAIT_OP, RD, FETCH_ACK, WR, DONE.
- IDLE: on start, set rd_ptr=0, wr_ptr=init_count, avail=init_count and go to ARB. start in any other state is ignored.
- Per-processor phase (2 bits): 0 expects FETCH, 1 expects FETCH, 2 expects SEND, then returns to 0.
- Eligibility: req[i]=1 AND (phase[i]!=0 OR avail-reserved>=2).
- ARB:
  - If every phase=0 and avail<=1 (including init_count 0 or 1), go to DONE.
  - Else pick the first eligible requester scanning from rr_ptr+1 upward, wrapping modulo NUM_PROC.
  - On a pick: grant[i]<=1, rr_ptr<=i, go to WAIT_OP. If the pick has phase 0, reserved+=2.
  - With no eligible requester, stay in ARB with grant=0.
- WAIT_OP (grant held):
  - NOP: stay.
  - FETCH while phase is 2: set proto_err and treat as SEND. SEND while phase is 0/1: set proto_err and treat as FETCH.
  - FETCH: mem_re<=1, mem_addr<=rd_ptr, go to RD.
  - SEND: mem_we<=1, mem_addr<=wr_ptr, mem_wdata<=write, signal<=1, go to WR.
- RD: mem_re<=0, go to FETCH_ACK with signal<=1.
- FETCH_ACK: read=mem_rdata. On exit:
  - signal<=0, grant<=0
  - rd_ptr+1 (wraps mod 2^ADDR_W), avail-1, reserved-1
  - phase+1, go to ARB.
- WR: on exit:
  - mem_we<=0, signal<=0, grant<=0
  - wr_ptr+1 (wraps), avail+1, phase<=0
  - go to ARB.
- Latency, counted from the edge where op is first sampled: FETCH gives signal 2 cycles later, for 1 cycle. SEND gives signal 1 cycle later, for 1 cycle. Grant falls on the edge that ends signal.
- Invariants: avail never exceeds init_count, so pointers never overrun each other. reserved<=avail always.
- DONE: done=1, grant=0, requests ignored. The final sum sits at mem address rd_ptr. Only reset leaves DONE.

Test Plan:
- Single processor, init_count=2, RAM[0]=5, RAM[1]=7, processor model runs REQ/FETCH/FETCH/SEND:
  - RAM[2]=12, avail=1, done=1
  - signal is exactly one cycle per transfer
  - FETCH latency is 2 cycles, SEND latency is 1 cycle.
- Four processors all requesting, init_count=8 with values 1..8:
  - grants rotate 1,2,3,0 (rr start 0)
  - final RAM value at rd_ptr is 36, done=1, proto_err=0.
- Reservation/deadlock: four processors, init_count=3:
  - only one phase-0 processor is granted (reserved=2, free=1)
  - completes with sum = total and done=1, with no stall.
- Wrap-around: ADDR_W=3, init_count=7:
  - wr_ptr wraps past 7 to 0 mid-run
  - final sum correct, avail never exceeds 7.
- Protocol error: granted phase-0 processor drives SEND → proto_err=1 (sticky), and the transfer is handled as FETCH.
- Reset asserted during RD: next cycle grant=0, signal=0, mem_re=0, state IDLE. A fresh start with init_count=2 completes normally.
